// File: rtl/fmap_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmap_streamer_pkg
// Description : Shared layer-stream definitions: Q16.16 word format, the
//               streamer state encoding and the feature-map flattening rule
//               (idx outermost, x middle, y innermost).
// Revision    : 1.0 - initial release
// ============================================================================
package fmap_streamer_pkg;

  localparam int Q_FRAC_BITS  = 16;
  localparam int Q_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Linear word address of element (idx, x, y) in a SIZE x SIZE x DEPTH map.
  function automatic int lin_addr(input int idx, input int x, input int y,
                                  input int size);
    return (idx * size + x) * size + y;
  endfunction

endpackage : fmap_streamer_pkg
`default_nettype wire

// File: rtl/fmap_tag_counter.sv
`default_nettype none
// ============================================================================
// Module      : fmap_tag_counter
// Description : Nested (idx, x, y) element counter, y innermost. Exposes the
//               registered current tag, the combinational next tag (what the
//               tag becomes at the coming edge) and a last-element flag.
// Ports       : clk, rst            clock / synchronous active-high reset
//               clear_i             force the tag to (0,0,0)
//               advance_i           step to the following element
//               idx_o/x_o/y_o       current tag
//               nxt_idx_o/x_o/y_o   next tag
//               last_o              current tag is (DEPTH-1, SIZE-1, SIZE-1)
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_tag_counter #(
  parameter int DEPTH       = 1,
  parameter int SIZE        = 13,
  parameter int IDX_WIDTH   = 3,
  parameter int COORD_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   advance_i,
  output logic [IDX_WIDTH-1:0]   idx_o,
  output logic [COORD_WIDTH-1:0] x_o,
  output logic [COORD_WIDTH-1:0] y_o,
  output logic [IDX_WIDTH-1:0]   nxt_idx_o,
  output logic [COORD_WIDTH-1:0] nxt_x_o,
  output logic [COORD_WIDTH-1:0] nxt_y_o,
  output logic                   last_o
);

  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic                   w_y_wrap, w_x_wrap, w_idx_wrap;

  assign w_y_wrap   = (int'(y_q) == SIZE - 1);
  assign w_x_wrap   = (int'(x_q) == SIZE - 1);
  assign w_idx_wrap = (int'(idx_q) == DEPTH - 1);

  always_comb begin
    idx_d = idx_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clear_i) begin
      idx_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (advance_i) begin
      if (!w_y_wrap) begin
        y_d = y_q + 1'b1;
      end else begin
        y_d = '0;
        if (!w_x_wrap) begin
          x_d = x_q + 1'b1;
        end else begin
          x_d   = '0;
          // Wrapping idx as well leaves the counter at (0,0,0) after a frame.
          idx_d = w_idx_wrap ? '0 : idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      idx_q <= idx_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign idx_o     = idx_q;
  assign x_o       = x_q;
  assign y_o       = y_q;
  assign nxt_idx_o = idx_d;
  assign nxt_x_o   = x_d;
  assign nxt_y_o   = y_d;
  assign last_o    = w_y_wrap && w_x_wrap && w_idx_wrap;

endmodule : fmap_tag_counter
`default_nettype wire

// File: rtl/fmap_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fmap_streamer
// Description : Feature-map transmitter. Buffers one DEPTH x SIZE x SIZE map
//               of Q16.16 words through a random-access write port and, on
//               start, streams every element once with its (idx, x, y) tag
//               over a valid/ready interface.
// Ports       : clk, rst                       clock / sync active-high reset
//               wr_en_i, wr_data_i             buffer write (IDLE only)
//               wr_idx_i, wr_x_i, wr_y_i       buffer write address
//               start_i                        begin streaming (IDLE only)
//               busy_o, done_o                 frame status
//               out_valid_o, out_rdy_i         stream handshake
//               out_data_o                     element value
//               out_idx_o, out_x_o, out_y_o    element tag
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_streamer
  import fmap_streamer_pkg::*;
#(
  parameter int DEPTH       = 1,
  parameter int SIZE        = 13,
  parameter int IDX_WIDTH   = 3,
  parameter int COORD_WIDTH = 5,
  parameter int DATA_WIDTH  = fmap_streamer_pkg::Q_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic [IDX_WIDTH-1:0]   wr_idx_i,
  input  logic [COORD_WIDTH-1:0] wr_x_i,
  input  logic [COORD_WIDTH-1:0] wr_y_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   out_valid_o,
  input  logic                   out_rdy_i,
  output logic [DATA_WIDTH-1:0]  out_data_o,
  output logic [IDX_WIDTH-1:0]   out_idx_o,
  output logic [COORD_WIDTH-1:0] out_x_o,
  output logic [COORD_WIDTH-1:0] out_y_o
);

  localparam int c_NUM_WORDS = DEPTH * SIZE * SIZE;
  localparam int c_ADDR_W    = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;

  state_e                 state_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic [DATA_WIDTH-1:0]  out_data_q;
  logic [DATA_WIDTH-1:0]  mem_q [c_NUM_WORDS];

  logic                   w_start;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_wr_ok;
  logic [c_ADDR_W-1:0]    w_wr_addr;
  logic [c_ADDR_W-1:0]    w_rd_addr;
  logic [IDX_WIDTH-1:0]   w_nxt_idx;
  logic [COORD_WIDTH-1:0] w_nxt_x;
  logic [COORD_WIDTH-1:0] w_nxt_y;

  assign w_start = (state_q == ST_IDLE) && start_i;
  assign w_xfer  = (state_q == ST_SEND) && out_valid_q && out_rdy_i;

  fmap_tag_counter #(
    .DEPTH       (DEPTH),
    .SIZE        (SIZE),
    .IDX_WIDTH   (IDX_WIDTH),
    .COORD_WIDTH (COORD_WIDTH)
  ) u_tag_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (w_start),
    .advance_i (w_xfer),
    .idx_o     (out_idx_o),
    .x_o       (out_x_o),
    .y_o       (out_y_o),
    .nxt_idx_o (w_nxt_idx),
    .nxt_x_o   (w_nxt_x),
    .nxt_y_o   (w_nxt_y),
    .last_o    (w_last)
  );

  // Out-of-range coordinates would alias onto other elements, so drop them.
  assign w_wr_ok = (state_q == ST_IDLE) && wr_en_i &&
                   (int'(wr_idx_i) < DEPTH) &&
                   (int'(wr_x_i) < SIZE) && (int'(wr_y_i) < SIZE);
  assign w_wr_addr = c_ADDR_W'(lin_addr(int'(wr_idx_i), int'(wr_x_i),
                                        int'(wr_y_i), SIZE));

  // Reading at the next tag lets out_data load in the same edge the tag
  // moves, so back-to-back transfers carry no bubble. The read sees memory
  // before any same-edge write, giving the pre-write value on a collision.
  assign w_rd_addr = c_ADDR_W'(lin_addr(int'(w_nxt_idx), int'(w_nxt_x),
                                        int'(w_nxt_y), SIZE));

  // Buffer storage is deliberately left out of reset so frames survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[w_wr_addr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q     <= ST_SEND;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            out_data_q  <= mem_q[w_rd_addr];
          end
        end
        ST_SEND: begin
          if (w_xfer) begin
            out_data_q <= mem_q[w_rd_addr];
            if (w_last) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign out_data_o  = out_data_q;

endmodule : fmap_streamer
`default_nettype wire

// File: tb/tb_fmap_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_streamer
// Description : Self-checking bench for fmap_streamer (DEPTH=2, SIZE=3).
//               A 3-D reference array holds the expected buffer; each frame's
//               expected element list is built from it with nested loops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_streamer;

  localparam int DEPTH = 2;
  localparam int SIZE  = 3;
  localparam int IW    = 3;
  localparam int CW    = 5;
  localparam int DW    = 32;
  localparam int N     = DEPTH * SIZE * SIZE;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic [IW-1:0] wr_idx_i;
  logic [CW-1:0] wr_x_i;
  logic [CW-1:0] wr_y_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          out_valid_o;
  logic          out_rdy_i;
  logic [DW-1:0] out_data_o;
  logic [IW-1:0] out_idx_o;
  logic [CW-1:0] out_x_o;
  logic [CW-1:0] out_y_o;

  always #5 clk = ~clk;

  fmap_streamer #(
    .DEPTH       (DEPTH),
    .SIZE        (SIZE),
    .IDX_WIDTH   (IW),
    .COORD_WIDTH (CW),
    .DATA_WIDTH  (DW)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
    .wr_idx_i    (wr_idx_i),
    .wr_x_i      (wr_x_i),
    .wr_y_i      (wr_y_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .out_valid_o (out_valid_o),
    .out_rdy_i   (out_rdy_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .out_x_o     (out_x_o),
    .out_y_o     (out_y_o)
  );

  typedef struct {
    int          idx;
    int          x;
    int          y;
    logic [31:0] data;
  } elem_t;

  typedef struct {
    int          idx;
    int          x;
    int          y;
    logic [31:0] data;
    bit          accept;
  } wr_vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [DEPTH][SIZE][SIZE];
  elem_t       exp_q[$];
  wr_vec_t     tbl[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected frame: every element once, idx outermost, y innermost.
  task automatic build_expected();
    elem_t e;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++)
      for (int x = 0; x < SIZE; x++)
        for (int y = 0; y < SIZE; y++) begin
          e.idx = i; e.x = x; e.y = y; e.data = ref_mem[i][x][y];
          exp_q.push_back(e);
        end
  endtask

  task automatic do_write(input int i, input int x, input int y,
                          input logic [31:0] d, input bit upd);
    wr_en_i   = 1'b1;
    wr_idx_i  = IW'(i);
    wr_x_i    = CW'(x);
    wr_y_i    = CW'(y);
    wr_data_i = d;
    @(negedge clk);
    wr_en_i = 1'b0;
    if (upd) ref_mem[i][x][y] = d;
  endtask

  // mode 0: out_rdy high; 1: pattern 1,0,0; 2: random out_rdy with random
  // writes and start pulses while sending.
  task automatic run_frame(input int mode, input bit collide,
                           input logic [31:0] cdata, input bit start_in_done);
    int cnt;
    int cyc;
    bit rdy;
    build_expected();
    start_i = 1'b1;
    if (collide) begin
      wr_en_i = 1'b1; wr_idx_i = '0; wr_x_i = '0; wr_y_i = '0;
      wr_data_i = cdata;
    end
    @(negedge clk);
    start_i = 1'b0;
    wr_en_i = 1'b0;
    if (collide) ref_mem[0][0][0] = cdata;
    cnt = 0;
    cyc = 0;
    while (cnt < N) begin
      if (cyc > 8 * N + 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_timeout: got %0d transfers expected %0d", cnt, N);
        break;
      end
      check($sformatf("elem%0d", cnt),
            {out_valid_o, busy_o, done_o, out_idx_o, out_x_o, out_y_o, out_data_o},
            {1'b1, 1'b1, 1'b0, IW'(exp_q[cnt].idx), CW'(exp_q[cnt].x),
             CW'(exp_q[cnt].y), exp_q[cnt].data});
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 3 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      out_rdy_i = rdy;
      if (mode == 2) begin
        wr_en_i   = 1'($urandom_range(0, 1));
        wr_idx_i  = IW'($urandom_range(0, DEPTH - 1));
        wr_x_i    = CW'($urandom_range(0, SIZE - 1));
        wr_y_i    = CW'($urandom_range(0, SIZE - 1));
        wr_data_i = $urandom;
        start_i   = ($urandom_range(0, 3) == 0);
      end
      if (rdy) cnt++;
      cyc++;
      @(negedge clk);
    end
    wr_en_i = 1'b0;
    start_i = 1'b0;
    if (mode == 0) check("frame_cycles", 64'(cyc), 64'(N));
    check("done_pulse", {out_valid_o, busy_o, done_o}, 3'b001);
    if (start_in_done) start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("after_done", {out_valid_o, busy_o, done_o}, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; wr_idx_i = '0;
    wr_x_i = '0; wr_y_i = '0; start_i = 1'b0; out_rdy_i = 1'b0;

    // Write table: the last field is whether the element must land.
    tbl[0] = '{0, 0, 0, 32'h1111_0000, 1'b1};
    tbl[1] = '{1, 2, 2, 32'h2222_0000, 1'b1};
    tbl[2] = '{0, 3, 0, 32'hBAD0_0001, 1'b0};  // x == SIZE
    tbl[3] = '{0, 0, 3, 32'hBAD0_0002, 1'b0};  // y == SIZE
    tbl[4] = '{2, 0, 0, 32'hBAD0_0003, 1'b0};  // idx == DEPTH
    tbl[5] = '{7, 31, 31, 32'hBAD0_0004, 1'b0};
    tbl[6] = '{1, 0, 2, 32'h3333_0000, 1'b1};
    tbl[7] = '{1, 3, 1, 32'hBAD0_0005, 1'b0};  // x == SIZE, channel 1

    repeat (3) @(negedge clk);
    check("reset_state",
          {out_valid_o, busy_o, done_o, out_idx_o, out_x_o, out_y_o, out_data_o},
          64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Integer ramp in Q16.16, then a free-flowing and a back-pressured frame.
    for (int i = 0; i < DEPTH; i++)
      for (int x = 0; x < SIZE; x++)
        for (int y = 0; y < SIZE; y++)
          do_write(i, x, y, 32'((i * SIZE * SIZE + x * SIZE + y) << 16), 1'b1);
    run_frame(0, 1'b0, '0, 1'b0);
    run_frame(1, 1'b0, '0, 1'b0);

    for (int k = 0; k < 8; k++)
      do_write(tbl[k].idx, tbl[k].x, tbl[k].y, tbl[k].data, tbl[k].accept);
    run_frame(0, 1'b0, '0, 1'b0);

    // Random contents; writes/starts during SEND must leave no trace.
    for (int i = 0; i < DEPTH; i++)
      for (int x = 0; x < SIZE; x++)
        for (int y = 0; y < SIZE; y++)
          do_write(i, x, y, $urandom, 1'b1);
    run_frame(2, 1'b0, '0, 1'b0);
    run_frame(0, 1'b0, '0, 1'b0);

    // Same-cycle write and start on element (0,0,0).
    run_frame(0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run_frame(1, 1'b0, '0, 1'b1);

    // Reset after the 4th transfer.
    build_expected();
    start_i = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    out_rdy_i = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_reset_tag", {out_valid_o, out_idx_o, out_x_o, out_y_o, out_data_o},
          {1'b1, IW'(exp_q[4].idx), CW'(exp_q[4].x), CW'(exp_q[4].y), exp_q[4].data});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset",
          {out_valid_o, busy_o, done_o, out_idx_o, out_x_o, out_y_o, out_data_o},
          64'h0);
    @(negedge clk);
    check("no_done_after_reset", {out_valid_o, busy_o, done_o}, 3'b000);
    run_frame(0, 1'b0, '0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      repeat (4) do_write($urandom_range(0, DEPTH - 1), $urandom_range(0, SIZE - 1),
                          $urandom_range(0, SIZE - 1), $urandom, 1'b1);
      run_frame(2, 1'b0, '0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fmap_streamer
`default_nettype wire
